// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback. Optional build macro: MCTRL_ILLEGAL_TRAP_EN.
//
// Memory handshake: mem_req (with mem_we and iord) is raised by the controller and
// held stable until the cycle in which mem_ready is sampled high; that cycle
// completes the transfer. mem_ready is ignored whenever mem_req is low.
module mcpu_ctrl #(
    parameter int OP_W = 3,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            alu_zero,
    input  logic            alu_bgtz,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_en,
    output logic [1:0]      pc_src,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [OP_W-1:0] alu_op,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] ALU_ZERO = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_NOR  = OP_W'(6);

    // Where an undecodable instruction goes: trap, or drop it as a NOP.
`ifdef MCTRL_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_HALT;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    state_t cur, nxt;

    always_ff @(posedge clk) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ZERO;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:       nxt = S_EXEC;
                    OP_LW, OP_SW:   nxt = S_MEMADR;
                    OP_ADDI:        nxt = S_ADDIEX;
                    OP_BEQ, OP_BGTZ: nxt = S_BRANCH;
                    OP_J:           nxt = S_JUMP;
                    default:        nxt = ILL_NEXT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                nxt       = S_RWB;
                case (funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b100110: alu_op = ALU_XOR;
                    6'b100111: alu_op = ALU_NOR;
                    default:   nxt    = ILL_NEXT;
                endcase
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                // bgtz has rt=$0, so the subtract leaves rs and the bgtz flag applies.
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_en     = (opcode == OP_BGTZ) ? alu_bgtz : alu_zero;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                nxt     = S_HALT;
`else
                nxt     = S_FETCH;
`endif
            end
            default: nxt = S_FETCH;
        endcase

        if (rst) begin
            nxt        = S_FETCH;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_op     = ALU_ZERO;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Table-driven bench for mcpu_ctrl: each row is one cycle of inputs plus the full
// expected control vector; a short hand-written sequence covers wait-state stability.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       alu_zero = 1'b0;
    logic       alu_bgtz = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcpu_ctrl #(.OP_W(3), .ST_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .alu_bgtz(alu_bgtz), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .state(state)
    );

    // Layout: {state, mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
    //          alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal}
    logic [20:0] act;
    assign act = {state, mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};

    function automatic logic [20:0] ex(input logic [3:0] st, input logic mreq, input logic mwe,
                                       input logic io, input logic irw, input logic pce,
                                       input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] aop,
                                       input logic rdst, input logic m2r, input logic rw,
                                       input logic ill);
        return {st, mreq, mwe, io, irw, pce, pcs, asa, asb, aop, rdst, m2r, rw, ill};
    endfunction

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        g;
        logic        rdy;
        logic        chk_st;
        logic [20:0] exp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input string name, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic g,
                       input logic rdy, input logic chk_st, input logic [20:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.g = g;
        v.rdy = rdy; v.chk_st = chk_st; v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [20:0] got,
                         input logic [20:0] want, input logic chk_st);
        logic [20:0] mask;
        mask = chk_st ? 21'h1fffff : 21'h01ffff;
        checks++;
        if ((got & mask) !== (want & mask)) begin
            errors++;
            $display("FAIL %s: got=%06h expected=%06h (mask %06h)", name, got, want, mask);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic g, input logic rdy);
        @(negedge clk);
        rst = r; opcode = op; funct = fn; alu_zero = z; alu_bgtz = g; mem_ready = rdy;
        #1;
    endtask

    logic [20:0] zero_v, f_rdy, f_wait, dec, radd_e, rwb, madr, mrd, mwb, mwr;
    logic [20:0] ill_e, halt_v;

    initial begin
        zero_v = 21'd0;
        f_rdy  = ex(4'd0, 1,0,0,1,1, 2'd0, 0, 2'd1, 3'd1, 0,0,0,0);
        f_wait = ex(4'd0, 1,0,0,0,0, 2'd0, 0, 2'd1, 3'd1, 0,0,0,0);
        dec    = ex(4'd1, 0,0,0,0,0, 2'd0, 0, 2'd3, 3'd1, 0,0,0,0);
        radd_e = ex(4'd6, 0,0,0,0,0, 2'd0, 1, 2'd0, 3'd1, 0,0,0,0);
        rwb    = ex(4'd7, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 1,0,1,0);
        madr   = ex(4'd2, 0,0,0,0,0, 2'd0, 1, 2'd2, 3'd1, 0,0,0,0);
        mrd    = ex(4'd3, 1,0,1,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0,0);
        mwb    = ex(4'd4, 0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,1,1,0);
        mwr    = ex(4'd5, 1,1,1,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0,0);
        ill_e  = ex(4'd6, 0,0,0,0,0, 2'd0, 1, 2'd0, 3'd0, 0,0,0,0);
        halt_v = ex(4'd12,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 0,0,0,1);

        //   name        rst op     fn     z g rdy chk exp
        add("reset0",    1, 6'h00, 6'h00, 0,0,1, 0, zero_v);
        add("reset1",    1, 6'h00, 6'h00, 0,0,1, 1, zero_v);
        add("radd_f",    0, 6'h00, 6'h20, 0,0,1, 1, f_rdy);
        add("radd_d",    0, 6'h00, 6'h20, 0,0,0, 1, dec);
        add("radd_e",    0, 6'h00, 6'h20, 0,0,1, 1, radd_e);
        add("radd_w",    0, 6'h00, 6'h20, 0,0,1, 1, rwb);
        add("lw_fw1",    0, 6'h23, 6'h00, 0,0,0, 1, f_wait);
        add("lw_fw2",    0, 6'h23, 6'h00, 0,0,0, 1, f_wait);
        add("lw_fr",     0, 6'h23, 6'h00, 0,0,1, 1, f_rdy);
        add("lw_d",      0, 6'h23, 6'h00, 0,0,1, 1, dec);
        add("lw_a",      0, 6'h23, 6'h00, 0,0,1, 1, madr);
        add("lw_rw",     0, 6'h23, 6'h00, 0,0,0, 1, mrd);
        add("lw_rr",     0, 6'h23, 6'h00, 0,0,1, 1, mrd);
        add("lw_wb",     0, 6'h23, 6'h00, 0,0,1, 1, mwb);
        add("beq1_f",    0, 6'h04, 6'h00, 1,0,1, 1, f_rdy);
        add("beq1_d",    0, 6'h04, 6'h00, 1,0,1, 1, dec);
        add("beq1_b",    0, 6'h04, 6'h00, 1,0,1, 1, ex(4'd8,0,0,0,0,1,2'd1,1,2'd0,3'd2,0,0,0,0));
        add("beq0_f",    0, 6'h04, 6'h00, 0,1,1, 1, f_rdy);
        add("beq0_d",    0, 6'h04, 6'h00, 0,1,1, 1, dec);
        add("beq0_b",    0, 6'h04, 6'h00, 0,1,1, 1, ex(4'd8,0,0,0,0,0,2'd1,1,2'd0,3'd2,0,0,0,0));
        add("bgtz1_f",   0, 6'h07, 6'h00, 0,1,1, 1, f_rdy);
        add("bgtz1_d",   0, 6'h07, 6'h00, 0,1,1, 1, dec);
        add("bgtz1_b",   0, 6'h07, 6'h00, 0,1,1, 1, ex(4'd8,0,0,0,0,1,2'd1,1,2'd0,3'd2,0,0,0,0));
        add("bgtz0_f",   0, 6'h07, 6'h00, 1,0,1, 1, f_rdy);
        add("bgtz0_d",   0, 6'h07, 6'h00, 1,0,1, 1, dec);
        add("bgtz0_b",   0, 6'h07, 6'h00, 1,0,1, 1, ex(4'd8,0,0,0,0,0,2'd1,1,2'd0,3'd2,0,0,0,0));
        add("sw_f",      0, 6'h2b, 6'h00, 0,0,1, 1, f_rdy);
        add("sw_d",      0, 6'h2b, 6'h00, 0,0,1, 1, dec);
        add("sw_a",      0, 6'h2b, 6'h00, 0,0,1, 1, madr);
        add("sw_w",      0, 6'h2b, 6'h00, 0,0,1, 1, mwr);
        add("addi_f",    0, 6'h08, 6'h00, 0,0,1, 1, f_rdy);
        add("addi_d",    0, 6'h08, 6'h00, 0,0,1, 1, dec);
        add("addi_e",    0, 6'h08, 6'h00, 0,0,1, 1, ex(4'd10,0,0,0,0,0,2'd0,1,2'd2,3'd1,0,0,0,0));
        add("addi_w",    0, 6'h08, 6'h00, 0,0,1, 1, ex(4'd11,0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,1,0));
        add("sub_f",     0, 6'h00, 6'h22, 0,0,1, 1, f_rdy);
        add("sub_d",     0, 6'h00, 6'h22, 0,0,1, 1, dec);
        add("sub_e",     0, 6'h00, 6'h22, 0,0,1, 1, ex(4'd6,0,0,0,0,0,2'd0,1,2'd0,3'd2,0,0,0,0));
        add("sub_w",     0, 6'h00, 6'h22, 0,0,1, 1, rwb);
        add("nor_f",     0, 6'h00, 6'h27, 0,0,1, 1, f_rdy);
        add("nor_d",     0, 6'h00, 6'h27, 0,0,1, 1, dec);
        add("nor_e",     0, 6'h00, 6'h27, 0,0,1, 1, ex(4'd6,0,0,0,0,0,2'd0,1,2'd0,3'd6,0,0,0,0));
        add("nor_w",     0, 6'h00, 6'h27, 0,0,1, 1, rwb);
        add("j_f",       0, 6'h02, 6'h00, 0,0,1, 1, f_rdy);
        add("j_d",       0, 6'h02, 6'h00, 0,0,1, 1, dec);
        add("j_j",       0, 6'h02, 6'h00, 0,0,1, 1, ex(4'd9,0,0,0,0,1,2'd2,0,2'd0,3'd0,0,0,0,0));
        add("rw_f",      0, 6'h2b, 6'h00, 0,0,1, 1, f_rdy);
        add("rw_d",      0, 6'h2b, 6'h00, 0,0,1, 1, dec);
        add("rw_a",      0, 6'h2b, 6'h00, 0,0,1, 1, madr);
        add("rw_w0",     0, 6'h2b, 6'h00, 0,0,0, 1, mwr);
        add("rw_rst1",   1, 6'h2b, 6'h00, 0,0,0, 0, zero_v);
        add("rw_rst2",   1, 6'h2b, 6'h00, 0,0,0, 1, zero_v);
        add("rw_fw",     0, 6'h2b, 6'h00, 0,0,0, 1, f_wait);
        add("ill_f",     0, 6'h00, 6'h00, 0,0,1, 1, f_rdy);
        add("ill_d",     0, 6'h00, 6'h00, 0,0,1, 1, dec);
        add("ill_e",     0, 6'h00, 6'h00, 0,0,1, 1, ill_e);
`ifdef MCTRL_ILLEGAL_TRAP_EN
        add("halt1",     0, 6'h00, 6'h00, 0,0,1, 1, halt_v);
        add("halt2",     0, 6'h00, 6'h00, 1,1,1, 1, halt_v);
        add("halt3",     0, 6'h00, 6'h00, 0,0,1, 1, halt_v);
        add("halt_rst1", 1, 6'h00, 6'h00, 0,0,1, 0, zero_v);
        add("halt_rst2", 1, 6'h00, 6'h00, 0,0,1, 1, zero_v);
        add("ill2_f",    0, 6'h3f, 6'h00, 0,0,1, 1, f_rdy);
        add("ill2_d",    0, 6'h3f, 6'h00, 0,0,1, 1, dec);
        add("halt4",     0, 6'h3f, 6'h00, 0,0,1, 1, halt_v);
        add("halt5",     0, 6'h3f, 6'h00, 0,0,1, 1, halt_v);
        add("halt_rst3", 1, 6'h3f, 6'h00, 0,0,1, 0, zero_v);
        add("halt_rst4", 1, 6'h3f, 6'h00, 0,0,1, 1, zero_v);
`else
        add("ill_nop",   0, 6'h00, 6'h00, 0,0,0, 1, f_wait);
        add("ill2_f",    0, 6'h3f, 6'h00, 0,0,1, 1, f_rdy);
        add("ill2_d",    0, 6'h3f, 6'h00, 0,0,1, 1, dec);
        add("ill2_nop",  0, 6'h3f, 6'h00, 0,0,0, 1, f_wait);
`endif

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].op, tv[i].fn, tv[i].z, tv[i].g, tv[i].rdy);
            check(tv[i].name, act, tv[i].exp, tv[i].chk_st);
        end

        // Multi-cycle corner: a long instruction fetch stall followed by a jump.
        step(1, 6'h02, 6'h00, 0, 0, 0);
        step(0, 6'h02, 6'h00, 0, 0, 0);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("stall_w%0d", w), act, f_wait, 1'b1);
            step(0, 6'h02, 6'h00, 0, 0, (w == 3));
        end
        check("stall_rdy", act, f_rdy, 1'b1);
        step(0, 6'h02, 6'h00, 0, 0, 1);
        check("stall_dec", act, dec, 1'b1);
        step(0, 6'h02, 6'h00, 0, 0, 1);
        check("stall_jump", act, ex(4'd9,0,0,0,0,1,2'd2,0,2'd0,3'd0,0,0,0,0), 1'b1);
        step(0, 6'h02, 6'h00, 0, 0, 0);
        check("stall_back", act, f_wait, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
Multicycle MIPS-subset control unit. It drives the ALU's alu_op port and the datapath mux selects and enables, and it consumes the ALU's branch flags. It sits between the instruction register / memory interface and the datapath, and issues one control vector per cycle. It sequences fetch, decode, execute, memory and writeback, with a ready handshake on memory.

Parameters:
OP_W, 3, width of alu_op; encodes 0 zero, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor.
ST_W, 4, width of the state/debug output.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  datapath flag, alu_out==0
alu_bgtz  in  1  ALU flag, alu_out>0 (signed)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = address is PC, 1 = address is ALUOut
ir_write  out  1  load IR
pc_en  out  1  load PC
pc_src  out  2  0 = ALU result, 1 = ALUOut reg, 2 = jump target {PC[31:28],IR[25:0],2'b00}
alu_src_a  out  1  0 = PC, 1 = A reg
alu_src_b  out  2  0 = B reg, 1 = const 4, 2 = sext(imm), 3 = sext(imm)<<2
alu_op  out  3  ALU operation
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
illegal  out  1  undecodable instruction seen
state  out  4  current state, for debug

Behaviour:
- Moore FSM with a registered state. Outputs decode from state only, except the mem_ready-gated enables noted below. Any output not listed for a state is 0.
- Reset: while rst=1, state<=FETCH(0) and all outputs are forced to 0, including mem_req. illegal is cleared. Reset mid-instruction abandons the instruction with no partial writes beyond those already clocked.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 12.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0. ir_write and pc_en are asserted only in the cycle mem_ready=1, and the FSM advances to DECODE in that cycle. Otherwise the FSM stays in FETCH with mem_req held.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 000000 (R-type) -> EXEC
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 001000 (addi) -> ADDIEX
  - 000100 (beq) / 000111 (bgtz) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> illegal path
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Advances to MEMWB on mem_ready.
- MEMWR: mem_req=1, mem_we=1, iord=1. Advances to FETCH on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next is FETCH.
- EXEC: alu_src_a=1, alu_src_b=0. funct maps to alu_op: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor. Any other funct takes the illegal path. Next is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=add. Next is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1.
  - beq: pc_en=alu_zero.
  - bgtz: pc_en=alu_bgtz (rt field is $0, so the ALU computes rs-0).
  - Next is FETCH.
- JUMP: pc_src=2, pc_en=1. Next is FETCH.
- Latency at zero wait states: R-type, addi and sw take 4 cycles; lw takes 5; beq, bgtz and j take 3. Each mem_ready-low cycle adds one cycle.
- mem_ready while mem_req=0 is ignored.
- mem_req, mem_we and iord stay stable until mem_ready is sampled high.

Optional Feature:
MCTRL_ILLEGAL_TRAP_EN
- Defined: the illegal path goes to HALT. HALT sets illegal=1 and drives all enables to 0. The FSM stays in HALT until rst.
- Undefined: the illegal path returns to FETCH with no writes (treated as a NOP). illegal stays 0 and HALT is unreachable.

Test Plan:
- Reset, then R-type add (opcode 0, funct 100000), mem_ready=1 always -> states 0,1,6,7,0; alu_op=1 in EXEC; reg_write=1 and reg_dst=1 in RWB only; pc_en=1 exactly once, in FETCH.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD -> total 8 cycles; mem_req held high throughout each wait with iord constant; ir_write pulses once, in the same cycle as mem_ready.
- beq, alu_zero=1, then beq with alu_zero=0 -> pc_en=1 with pc_src=1 in BRANCH for the first; pc_en=0 for the second; both return to FETCH.
- bgtz with alu_bgtz=1, alu_zero=0 -> pc_en=1 in BRANCH, alu_op=2; repeat with alu_bgtz=0 -> pc_en=0.
- funct 000000 with opcode 0, and opcode 111111 -> with the macro: state=12, illegal=1, mem_req stays 0 until rst. Without the macro: back to FETCH, no reg_write or pc_en beyond the fetch.
- rst=1 asserted in MEMWR while mem_ready=0 -> next cycle mem_req=0, mem_we=0, state=0. After rst is released, FETCH issues mem_req=1 with iord=0.
